// File: rtl/mips_multicycle_core_if.sv
// Host-side bus of mips_multicycle_core: program/data loading, run control and debug views.
interface mips_multicycle_core_if #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned IMEM_AW = 5,
    parameter int unsigned DMEM_AW = 5
);
    logic               start;
    logic               imem_we;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_wdata;
    logic               dmem_we;
    logic [DMEM_AW-1:0] dmem_addr;
    logic [DATA_W-1:0]  dmem_wdata;
    logic [DATA_W-1:0]  dmem_rdata;
    logic [4:0]         reg_sel;
    logic [DATA_W-1:0]  reg_rdata;
    logic               busy;
    logic               done;
    logic               error;
    logic [IMEM_AW-1:0] pc;
    logic [31:0]        cycle_count;

    // Host / controller side
    modport master (
        output start, imem_we, imem_addr, imem_wdata, dmem_we, dmem_addr, dmem_wdata, reg_sel,
        input  dmem_rdata, reg_rdata, busy, done, error, pc, cycle_count
    );

    // Core side
    modport slave (
        input  start, imem_we, imem_addr, imem_wdata, dmem_we, dmem_addr, dmem_wdata, reg_sel,
        output dmem_rdata, reg_rdata, busy, done, error, pc, cycle_count
    );
endinterface

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS-style core: fetch/decode/execute/memory/writeback FSM running a host-loaded
// program from local instruction memory against a local data memory.
module mips_multicycle_core #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned IMEM_AW = 5,
    parameter int unsigned DMEM_AW = 5
) (
    input logic                   clock,
    input logic                   reset,
    mips_multicycle_core_if.slave bus
);
    localparam logic [5:0] OpNop   = 6'h00;
    localparam logic [5:0] OpAddu  = 6'h01;
    localparam logic [5:0] OpBeq   = 6'h02;
    localparam logic [5:0] OpLw    = 6'h03;
    localparam logic [5:0] OpMul   = 6'h04;
    localparam logic [5:0] OpAddiu = 6'h05;
    localparam logic [5:0] OpSw    = 6'h06;
    localparam logic [5:0] OpJ     = 6'h07;
    localparam logic [5:0] OpJr    = 6'h08;
    localparam logic [5:0] OpHalt  = 6'h3F;

    typedef enum logic [2:0] {
        StIdle, StFetch, StDecode, StExec, StMem, StWb, StHalt
    } state_e;

    state_e state_q, state_d;

    logic [31:0]        imem [2**IMEM_AW];
    logic [DATA_W-1:0]  dmem [2**DMEM_AW];
    logic [DATA_W-1:0]  regs_q [32];  // entry 0 is never written, so it always reads 0
    logic [31:0]        ir_q;
    logic [DATA_W-1:0]  a_q, b_q, alu_q, mdr_q, host_rdata_q;
    logic [IMEM_AW-1:0] pc_q;
    logic [31:0]        cycle_q;
    logic               error_q, done_q;

    logic [5:0]         op;
    logic [4:0]         rs, rt, rd, wb_idx;
    logic [DATA_W-1:0]  imm_ext, wb_val;
    logic [DMEM_AW-1:0] mem_idx;
    logic               busy, start_ok, op_legal, illegal, wb_en;

    // Instruction field decode and control strobes
    always_comb begin
        op       = ir_q[31:26];
        rs       = ir_q[25:21];
        rt       = ir_q[20:16];
        rd       = ir_q[15:11];
        imm_ext  = DATA_W'($signed(ir_q[15:0]));
        busy     = (state_q != StIdle) && (state_q != StHalt);
        start_ok = bus.start && !busy;
        op_legal = op inside {OpNop, OpAddu, OpBeq, OpLw, OpMul, OpAddiu, OpSw, OpJ, OpJr};
        illegal  = (state_q == StExec) && !op_legal && (op != OpHalt);
        mem_idx  = alu_q[DMEM_AW-1:0];
        wb_idx   = ((op == OpAddu) || (op == OpMul)) ? rd : rt;
        wb_val   = (op == OpLw) ? mdr_q : alu_q;
        wb_en    = (state_q == StWb) && (wb_idx != 5'd0);
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StHalt: if (bus.start) state_d = StFetch;
            StFetch:        state_d = StDecode;
            StDecode:       state_d = StExec;
            StExec: begin
                case (op)
                    OpNop, OpBeq, OpJ, OpJr: state_d = StFetch;
                    OpAddu, OpMul, OpAddiu:  state_d = StWb;
                    OpLw, OpSw:              state_d = StMem;
                    default:                 state_d = StHalt;  // halt or illegal opcode
                endcase
            end
            StMem:   state_d = (op == OpLw) ? StWb : StFetch;
            StWb:    state_d = StFetch;
            default: state_d = StIdle;
        endcase
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Datapath, program counter, status and host read port
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q         <= '0;
            ir_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            alu_q        <= '0;
            mdr_q        <= '0;
            cycle_q      <= '0;
            error_q      <= 1'b0;
            done_q       <= 1'b0;
            host_rdata_q <= '0;
        end else begin
            host_rdata_q <= dmem[bus.dmem_addr];
            done_q       <= (state_d == StHalt) && (state_q != StHalt);
            if (start_ok) begin
                pc_q    <= '0;
                cycle_q <= '0;
                error_q <= 1'b0;
            end else if (busy && (cycle_q != '1)) begin
                cycle_q <= cycle_q + 32'd1;
            end
            if (illegal) error_q <= 1'b1;
            case (state_q)
                StFetch:  ir_q <= imem[pc_q];
                StDecode: begin
                    a_q <= regs_q[rs];
                    b_q <= regs_q[rt];
                end
                StExec: begin
                    case (op)
                        OpAddu:             alu_q <= a_q + b_q;
                        OpMul:              alu_q <= a_q * b_q;
                        OpLw, OpSw, OpAddiu: alu_q <= a_q + imm_ext;
                        default: ;
                    endcase
                    case (op)
                        OpBeq: pc_q <= (a_q == b_q) ? pc_q + IMEM_AW'(1) + ir_q[IMEM_AW-1:0]
                                                    : pc_q + IMEM_AW'(1);
                        OpJ:     pc_q <= ir_q[IMEM_AW-1:0];
                        OpJr:    pc_q <= a_q[IMEM_AW-1:0];
                        default: if (op_legal) pc_q <= pc_q + IMEM_AW'(1);  // halt/illegal hold pc
                    endcase
                end
                StMem: mdr_q <= dmem[mem_idx];
                default: ;
            endcase
        end
    end

    // Register file writeback
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (wb_en) begin
            regs_q[wb_idx] <= wb_val;
        end
    end

    // Instruction memory host load port
    always_ff @(posedge clock) begin
        if (bus.imem_we && !busy) imem[bus.imem_addr] <= bus.imem_wdata;
    end

    // Data memory: core store wins; host writes only land while the core is stopped
    always_ff @(posedge clock) begin
        if ((state_q == StMem) && (op == OpSw)) dmem[mem_idx] <= b_q;
        else if (bus.dmem_we && !busy)         dmem[bus.dmem_addr] <= bus.dmem_wdata;
    end

    assign bus.dmem_rdata  = host_rdata_q;
    assign bus.reg_rdata   = (bus.reg_sel == 5'd0) ? '0 : regs_q[bus.reg_sel];
    assign bus.busy        = busy;
    assign bus.done        = done_q;
    assign bus.error       = error_q;
    assign bus.pc          = pc_q;
    assign bus.cycle_count = cycle_q;
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Self-checking bench for mips_multicycle_core: directed vectors, corner sequences and random
// programs compared against an instruction-level reference interpreter.
module tb_mips_multicycle_core;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned IMEM_AW = 5;
    localparam int unsigned DMEM_AW = 5;

    localparam int OP_NOP = 0, OP_ADDU = 1, OP_BEQ = 2, OP_LW = 3, OP_MUL = 4;
    localparam int OP_ADDIU = 5, OP_SW = 6, OP_J = 7, OP_JR = 8, OP_HALT = 63;

    logic clock = 1'b0;
    logic reset = 1'b1;

    mips_multicycle_core_if #(.DATA_W(DATA_W), .IMEM_AW(IMEM_AW), .DMEM_AW(DMEM_AW)) bus ();

    mips_multicycle_core #(.DATA_W(DATA_W), .IMEM_AW(IMEM_AW), .DMEM_AW(DMEM_AW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference machine state
    logic [31:0] m_imem [32];
    logic [31:0] m_dmem [32];
    logic [31:0] m_regs [32];
    logic [4:0]  m_pc;
    logic        m_err;
    int          m_cycles;

    typedef struct {
        string       name;
        int          op;
        logic [31:0] a;
        logic [31:0] b;
        int          imm;
        logic [31:0] exp;
        int          exp_cyc;
        int          exp_pc;
    } vec_t;

    vec_t vecs[11];

    function automatic logic [31:0] r_ins(input int op, input int rs, input int rt, input int rd);
        return {op[5:0], rs[4:0], rt[4:0], rd[4:0], 11'b0};
    endfunction

    function automatic logic [31:0] i_ins(input int op, input int rs, input int rt, input int imm);
        return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        bus.start      = 1'b0;
        bus.imem_we    = 1'b0;
        bus.imem_addr  = '0;
        bus.imem_wdata = '0;
        bus.dmem_we    = 1'b0;
        bus.dmem_addr  = '0;
        bus.dmem_wdata = '0;
        bus.reg_sel    = '0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        set_idle();
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
    endtask

    task automatic fill_halt();
        for (int i = 0; i < 32; i++) begin
            m_imem[i] = r_ins(OP_HALT, 0, 0, 0);
            m_dmem[i] = '0;
        end
    endtask

    task automatic load_all();
        for (int i = 0; i < 32; i++) begin
            @(negedge clock);
            bus.imem_we = 1'b1; bus.imem_addr = 5'(i); bus.imem_wdata = m_imem[i];
            bus.dmem_we = 1'b1; bus.dmem_addr = 5'(i); bus.dmem_wdata = m_dmem[i];
        end
        @(negedge clock);
        bus.imem_we = 1'b0;
        bus.dmem_we = 1'b0;
    endtask

    task automatic read_reg(input int idx, output logic [31:0] v);
        bus.reg_sel = 5'(idx);
        #1;
        v = bus.reg_rdata;
    endtask

    task automatic read_dmem(input int addr, output logic [31:0] v);
        bus.dmem_addr = 5'(addr);
        @(posedge clock);
        @(negedge clock);
        v = bus.dmem_rdata;
    endtask

    task automatic pulse_start();
        @(negedge clock);
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
    endtask

    // k counts clock edges since the edge that accepted start
    task automatic wait_done(input int k0, input int budget, output int k);
        k = k0;
        while (!bus.done && k < budget) begin
            @(negedge clock);
            k++;
        end
        checks++;
        if (!bus.done) begin
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done", k);
        end
    endtask

    task automatic m_wr(input logic [4:0] idx, input logic [31:0] v);
        if (idx != 5'd0) m_regs[idx] = v;
    endtask

    // Instruction-level interpreter with fixed per-instruction cycle costs
    task automatic model_run();
        logic [31:0] ins, a, b, imm, ea;
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd;
        bit          stop;
        int          steps;
        stop = 0; steps = 0;
        m_pc = '0; m_err = 1'b0; m_cycles = 0;
        while (!stop && steps < 2000) begin
            ins = m_imem[m_pc];
            op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
            imm = {{16{ins[15]}}, ins[15:0]};
            a = m_regs[rs]; b = m_regs[rt];
            ea = a + imm;
            steps++;
            case (int'(op))
                OP_NOP:   begin m_pc = m_pc + 1; m_cycles += 3; end
                OP_ADDU:  begin m_wr(rd, a + b); m_pc = m_pc + 1; m_cycles += 4; end
                OP_BEQ:   begin
                    if (a == b) m_pc = m_pc + 1 + imm[4:0];
                    else        m_pc = m_pc + 1;
                    m_cycles += 3;
                end
                OP_LW:    begin m_wr(rt, m_dmem[ea % 32]); m_pc = m_pc + 1; m_cycles += 5; end
                OP_MUL:   begin m_wr(rd, a * b); m_pc = m_pc + 1; m_cycles += 4; end
                OP_ADDIU: begin m_wr(rt, ea); m_pc = m_pc + 1; m_cycles += 4; end
                OP_SW:    begin m_dmem[ea % 32] = b; m_pc = m_pc + 1; m_cycles += 4; end
                OP_J:     begin m_pc = imm[4:0]; m_cycles += 3; end
                OP_JR:    begin m_pc = a[4:0]; m_cycles += 3; end
                OP_HALT:  begin m_cycles += 3; stop = 1; end
                default:  begin m_err = 1'b1; m_cycles += 3; stop = 1; end
            endcase
        end
    endtask

    task automatic compare_all(input string name, input int k);
        logic [31:0] v;
        check({name, " cycles"}, k, m_cycles);
        check({name, " cycle_count"}, bus.cycle_count, m_cycles);
        check({name, " error"}, {31'b0, bus.error}, {31'b0, m_err});
        check({name, " pc"}, {27'b0, bus.pc}, {27'b0, m_pc});
        for (int i = 1; i < 32; i++) begin
            read_reg(i, v);
            check($sformatf("%s r%0d", name, i), v, m_regs[i]);
        end
        for (int i = 0; i < 32; i++) begin
            read_dmem(i, v);
            check($sformatf("%s dmem[%0d]", name, i), v, m_dmem[i]);
        end
    endtask

    // Load, run to done against the model, and compare full architectural state
    task automatic run_model_test(input string name, output int k);
        load_all();
        model_run();
        pulse_start();
        wait_done(0, 400, k);
        compare_all(name, k);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k;
        logic [31:0] v;

        set_idle();
        // Reset state, sampled while reset is held
        @(negedge clock);
        check("rst busy", {31'b0, bus.busy}, 32'd0);
        check("rst done", {31'b0, bus.done}, 32'd0);
        check("rst error", {31'b0, bus.error}, 32'd0);
        check("rst pc", {27'b0, bus.pc}, 32'd0);
        check("rst cycle_count", bus.cycle_count, 32'd0);
        check("rst dmem_rdata", bus.dmem_rdata, 32'd0);
        read_reg(5, v);
        check("rst r5", v, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Single-operation vectors: lw r1,0(r0); lw r2,1(r0); <op>; halt
        vecs[0]  = '{"addu",       OP_ADDU,  32'd5,        32'd7,        0,      32'd12,       4, 3};
        vecs[1]  = '{"addu_wrap",  OP_ADDU,  32'hFFFFFFFF, 32'd1,        0,      32'd0,        4, 3};
        vecs[2]  = '{"mul",        OP_MUL,   32'd3,        32'd7,        0,      32'd21,       4, 3};
        vecs[3]  = '{"mul_hi",     OP_MUL,   32'h00010000, 32'h00010000, 0,      32'd0,        4, 3};
        vecs[4]  = '{"mul_neg",    OP_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 0,      32'd1,        4, 3};
        vecs[5]  = '{"addiu_neg",  OP_ADDIU, 32'd10,       32'd0,        -3,     32'd7,        4, 3};
        vecs[6]  = '{"addiu_ovf",  OP_ADDIU, 32'h7FFFFFFF, 32'd0,        1,      32'h80000000, 4, 3};
        vecs[7]  = '{"addiu_min",  OP_ADDIU, 32'd0,        32'd0,        -32768, 32'hFFFF8000, 4, 3};
        vecs[8]  = '{"beq_taken",  OP_BEQ,   32'd4,        32'd4,        1,      32'd0,        3, 4};
        vecs[9]  = '{"beq_not",    OP_BEQ,   32'd4,        32'd5,        1,      32'd0,        3, 3};
        vecs[10] = '{"nop",        OP_NOP,   32'd9,        32'd9,        0,      32'd0,        3, 3};

        for (int t = 0; t < 11; t++) begin
            do_reset();
            fill_halt();
            m_imem[0] = i_ins(OP_LW, 0, 1, 0);
            m_imem[1] = i_ins(OP_LW, 0, 2, 1);
            if (vecs[t].op == OP_ADDIU)    m_imem[2] = i_ins(OP_ADDIU, 1, 3, vecs[t].imm);
            else if (vecs[t].op == OP_BEQ) m_imem[2] = i_ins(OP_BEQ, 1, 2, vecs[t].imm);
            else                           m_imem[2] = r_ins(vecs[t].op, 1, 2, 3);
            m_dmem[0] = vecs[t].a;
            m_dmem[1] = vecs[t].b;
            load_all();
            pulse_start();
            wait_done(0, 100, k);
            check({vecs[t].name, " cycles"}, k, 5 + 5 + vecs[t].exp_cyc + 3);
            check({vecs[t].name, " pc"}, {27'b0, bus.pc}, vecs[t].exp_pc);
            check({vecs[t].name, " error"}, {31'b0, bus.error}, 32'd0);
            read_reg(3, v);
            check({vecs[t].name, " r3"}, v, vecs[t].exp);
        end

        // Dot product of {1,2,3} and {4,5,6}
        do_reset();
        fill_halt();
        m_imem[0]  = i_ins(OP_ADDIU, 0, 3, 0);
        m_imem[1]  = i_ins(OP_ADDIU, 0, 5, 4);
        m_imem[2]  = i_ins(OP_ADDIU, 0, 7, 3);
        m_imem[3]  = i_ins(OP_LW, 3, 2, 0);
        m_imem[4]  = i_ins(OP_LW, 5, 4, 0);
        m_imem[5]  = r_ins(OP_MUL, 2, 4, 6);
        m_imem[6]  = r_ins(OP_ADDU, 1, 6, 1);
        m_imem[7]  = i_ins(OP_ADDIU, 3, 3, 1);
        m_imem[8]  = i_ins(OP_ADDIU, 5, 5, 1);
        m_imem[9]  = i_ins(OP_ADDIU, 7, 7, -1);
        m_imem[10] = i_ins(OP_BEQ, 7, 0, 1);
        m_imem[11] = i_ins(OP_J, 0, 0, 3);
        m_dmem[0] = 1; m_dmem[1] = 2; m_dmem[2] = 3;
        m_dmem[4] = 4; m_dmem[5] = 5; m_dmem[6] = 6;
        run_model_test("dot", k);
        read_reg(1, v); check("dot r1", v, 32'd32);
        read_reg(7, v); check("dot r7", v, 32'd0);
        check("dot error", {31'b0, bus.error}, 32'd0);

        // Writes to r0 are discarded
        do_reset();
        fill_halt();
        m_imem[0] = i_ins(OP_ADDIU, 0, 2, 7);
        m_imem[1] = i_ins(OP_ADDIU, 0, 0, 5);
        m_imem[2] = r_ins(OP_ADDU, 0, 0, 2);
        m_imem[3] = i_ins(OP_ADDIU, 0, 1, -1);
        run_model_test("r0", k);
        read_reg(0, v); check("r0 r0", v, 32'd0);
        read_reg(2, v); check("r0 r2", v, 32'd0);
        read_reg(1, v); check("r0 r1", v, 32'hFFFFFFFF);

        // Store then load at an effective address that wraps to word 1
        do_reset();
        fill_halt();
        for (int i = 0; i < 32; i++) m_dmem[i] = $urandom;
        m_dmem[1] = '0;
        m_imem[0] = i_ins(OP_ADDIU, 0, 1, 16'h1234);
        m_imem[1] = i_ins(OP_ADDIU, 0, 4, 30);
        m_imem[2] = i_ins(OP_SW, 4, 1, 3);
        m_imem[3] = i_ins(OP_LW, 4, 2, 3);
        run_model_test("swlw", k);
        read_dmem(1, v); check("swlw dmem[1]", v, 32'h1234);
        read_reg(2, v);  check("swlw r2", v, 32'h1234);

        // Register-indirect jump skips pc 2
        do_reset();
        fill_halt();
        m_imem[0] = i_ins(OP_ADDIU, 0, 1, 5);
        m_imem[1] = r_ins(OP_JR, 1, 0, 0);
        m_imem[2] = i_ins(OP_ADDIU, 0, 2, 9);
        m_imem[3] = r_ins(OP_NOP, 0, 0, 0);
        m_imem[4] = r_ins(OP_NOP, 0, 0, 0);
        run_model_test("jr", k);
        check("jr pc", {27'b0, bus.pc}, 32'd5);
        read_reg(2, v); check("jr r2", v, 32'd0);

        // Illegal opcode at pc 2; restart with a same-cycle host write
        do_reset();
        fill_halt();
        m_imem[0] = r_ins(OP_NOP, 0, 0, 0);
        m_imem[1] = r_ins(OP_NOP, 0, 0, 0);
        m_imem[2] = r_ins(6'h2A, 0, 0, 0);
        run_model_test("illegal", k);
        check("illegal k", k, 32'd9);
        check("illegal error", {31'b0, bus.error}, 32'd1);
        check("illegal pc", {27'b0, bus.pc}, 32'd2);
        @(negedge clock);
        bus.start = 1'b1; bus.dmem_we = 1'b1; bus.dmem_addr = 5'd12; bus.dmem_wdata = 32'h77;
        @(negedge clock);
        bus.start = 1'b0; bus.dmem_we = 1'b0;
        check("restart error cleared", {31'b0, bus.error}, 32'd0);
        check("restart busy", {31'b0, bus.busy}, 32'd1);
        wait_done(0, 100, k);
        check("restart error again", {31'b0, bus.error}, 32'd1);
        read_dmem(12, v); check("restart dmem[12]", v, 32'h77);

        // Timing: addu (4) + halt (3)
        do_reset();
        fill_halt();
        m_imem[0] = r_ins(OP_ADDU, 1, 2, 3);
        load_all();
        pulse_start();
        check("timing busy", {31'b0, bus.busy}, 32'd1);
        wait_done(0, 100, k);
        check("timing k", k, 32'd7);
        check("timing cycle_count", bus.cycle_count, 32'd7);
        check("timing busy low", {31'b0, bus.busy}, 32'd0);
        @(negedge clock);
        check("timing done pulse", {31'b0, bus.done}, 32'd0);
        repeat (3) @(negedge clock);
        check("timing count frozen", bus.cycle_count, 32'd7);

        // start and host data write while busy are ignored
        do_reset();
        fill_halt();
        for (int i = 0; i < 6; i++) m_imem[i] = r_ins(OP_NOP, 0, 0, 0);
        m_dmem[9] = 32'h55;
        load_all();
        pulse_start();
        repeat (5) @(negedge clock);
        bus.start = 1'b1; bus.dmem_we = 1'b1; bus.dmem_addr = 5'd9; bus.dmem_wdata = 32'hDEAD;
        @(negedge clock);
        bus.start = 1'b0; bus.dmem_we = 1'b0;
        check("midrun cycle_count", bus.cycle_count, 32'd6);
        wait_done(6, 100, k);
        check("midrun k", k, 32'd21);
        check("midrun cycle_count end", bus.cycle_count, 32'd21);
        read_dmem(9, v); check("midrun dmem[9]", v, 32'h55);

        // beq r0,r0,-1 spins at pc 3; reset mid-run returns to idle
        do_reset();
        fill_halt();
        for (int i = 0; i < 3; i++) m_imem[i] = r_ins(OP_NOP, 0, 0, 0);
        m_imem[3] = i_ins(OP_BEQ, 0, 0, -1);
        load_all();
        pulse_start();
        repeat (30) @(negedge clock);
        check("spin pc", {27'b0, bus.pc}, 32'd3);
        check("spin busy", {31'b0, bus.busy}, 32'd1);
        check("spin done", {31'b0, bus.done}, 32'd0);
        check("spin cycle_count", bus.cycle_count, 32'd30);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check($sformatf("spin pc +%0d", i + 1), {27'b0, bus.pc}, 32'd3);
        end
        reset = 1'b1;
        #1;
        check("midreset busy", {31'b0, bus.busy}, 32'd0);
        check("midreset pc", {27'b0, bus.pc}, 32'd0);
        check("midreset cycle_count", bus.cycle_count, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("post reset busy", {31'b0, bus.busy}, 32'd0);
        check("post reset pc", {27'b0, bus.pc}, 32'd0);

        // Random forward-flowing programs against the reference interpreter
        for (int t = 0; t < 6; t++) begin
            int n;
            do_reset();
            fill_halt();
            for (int i = 0; i < 32; i++) m_dmem[i] = $urandom;
            n = $urandom_range(8, 16);
            for (int p = 0; p < n; p++) begin
                int sel, rs, rt, rd;
                sel = $urandom_range(0, 9);
                rs  = $urandom_range(0, 5);
                rt  = $urandom_range(0, 5);
                rd  = $urandom_range(0, 5);
                case (sel)
                    0:       m_imem[p] = r_ins(OP_NOP, 0, 0, 0);
                    1:       m_imem[p] = r_ins(OP_ADDU, rs, rt, rd);
                    2:       m_imem[p] = r_ins(OP_MUL, rs, rt, rd);
                    3, 4:    m_imem[p] = i_ins(OP_ADDIU, rs, rt, $urandom_range(0, 65535));
                    5:       m_imem[p] = i_ins(OP_LW, rs, rt, $urandom_range(0, 65535));
                    6:       m_imem[p] = i_ins(OP_SW, rs, rt, $urandom_range(0, 65535));
                    7:       m_imem[p] = i_ins(OP_BEQ, $urandom_range(0, 2), $urandom_range(0, 2),
                                               $urandom_range(0, 3));
                    8:       m_imem[p] = i_ins(OP_J, 0, 0, p + $urandom_range(1, 3));
                    default: begin
                        if ($urandom_range(0, 3) == 0) m_imem[p] = r_ins($urandom_range(9, 62), 0, 0, 0);
                        else                           m_imem[p] = r_ins(OP_ADDU, rs, rt, rd);
                    end
                endcase
            end
            run_model_test($sformatf("rand%0d", t), k);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
